// File: rtl/rtc_prog_sequencer.sv
// RTC programming sequencer: walks a masked set of registers and issues an address
// phase then a data phase per register through the bus engine's start/done handshake.
module rtc_prog_sequencer #(
    parameter int               N_REGS    = 9,
    parameter int               ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h21,
    parameter int               IDX_W     = 4,
    parameter int               TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_REGS-1:0] reg_mask,
    input  logic              bus_done,
    output logic              bus_start,
    output logic              ad_w,
    output logic              op_w,
    output logic [ADDR_W-1:0] addr_w,
    output logic [IDX_W-1:0]  sel_prog,
    output logic [1:0]        data_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SCAN      = 3'd1;
    localparam logic [2:0] S_ADDR_PH   = 3'd2;
    localparam logic [2:0] S_ADDR_WAIT = 3'd3;
    localparam logic [2:0] S_DATA_PH   = 3'd4;
    localparam logic [2:0] S_DATA_WAIT = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [N_REGS-1:0] mask_q;
    logic [CNT_W-1:0]  cnt;

    wire last = (idx == LAST_IDX);

    // NOTE: every register in this block uses <= so all state updates see the
    // pre-edge values; mixing in = here would make ordering inside the block matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            mask_q <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= reg_mask;
                        idx    <= '0;
                        err    <= 1'b0;
                        state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (mask_q[idx]) begin
                        state <= S_ADDR_PH;
                    end else if (last) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_ADDR_PH: begin
                    cnt   <= '0;
                    state <= S_ADDR_WAIT;
                end
                // bus_done is tested before the limit so a completion on the last
                // allowed cycle is still accepted.
                S_ADDR_WAIT: begin
                    if (bus_done) begin
                        state <= S_DATA_PH;
                    end else if (cnt == CNT_MAX) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA_PH: begin
                    cnt   <= '0;
                    state <= S_DATA_WAIT;
                end
                S_DATA_WAIT: begin
                    if (bus_done) begin
                        state <= S_NEXT;
                    end else if (cnt == CNT_MAX) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: each output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        bus_start = 1'b0;
        ad_w      = 1'b0;
        op_w      = 1'b1;
        data_sel  = 2'b10;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                op_w = 1'b0;
                busy = 1'b0;
            end
            S_ADDR_PH: begin
                bus_start = 1'b1;
                data_sel  = 2'b00;
            end
            S_ADDR_WAIT: data_sel = 2'b00;
            S_DATA_PH: begin
                bus_start = 1'b1;
                ad_w      = 1'b1;
                data_sel  = 2'b01;
            end
            S_DATA_WAIT: begin
                ad_w     = 1'b1;
                data_sel = 2'b01;
            end
            S_DONE: begin
                op_w = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Address and mux select follow idx, which only moves in SCAN and NEXT.
    assign addr_w   = BASE_ADDR + ADDR_W'(idx);
    assign sel_prog = idx;

endmodule

// File: doc/rtc_prog_sequencer.md
Name: rtc_prog_sequencer

Overview:
- Parametrised successor to the team's RTC "programar" write controller.
- Walks a configurable set of RTC registers and performs a two-phase write on each selected register: an address phase, then a data phase.
- Each phase is handed to the existing bus write/read engine through a start/finish handshake.
- New relative to the fixed-sequence controller: register count is a parameter, there is a per-register skip mask, each bus transaction has a timeout with a sticky error, and completion is signalled explicitly.

Parameters:
- N_REGS, 9: number of RTC registers in the programming sequence.
- ADDR_W, 8: width of the RTC register address.
- BASE_ADDR, 8'h21: RTC address of register index 0; register i uses address BASE_ADDR+i.
- IDX_W, 4: width of the register index. Must satisfy 2**IDX_W >= N_REGS+1.
- TIMEOUT, 255: maximum number of cycles to wait for bus_done.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: request to program the RTC. Level or pulse; sampled only in IDLE.
- reg_mask, in, N_REGS: bit i=1 means write register i. Captured on start.
- bus_done, in, 1: one-cycle pulse from the bus engine when a transaction finishes.
- bus_start, out, 1: one-cycle pulse that launches one bus transaction.
- ad_w, out, 1: 0 = address phase, 1 = data phase.
- op_w, out, 1: write operation in progress; feeds the bus engine's R/W select.
- addr_w, out, ADDR_W: BASE_ADDR + current index.
- sel_prog, out, IDX_W: current register index; selects the data source mux.
- data_sel, out, 2: bus data mux select. 00 = addr_w, 01 = programmed value, 10 = idle/0xFF.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at the end of the sequence, whether it completed or aborted.
- err, out, 1: sticky timeout flag.

Behaviour:
- Reset (synchronous): state=IDLE, idx=0, mask register=0, timeout counter=0. All outputs 0, except data_sel=10 and addr_w=BASE_ADDR. err cleared.
- All outputs are registered or decoded from registered state only. No input-to-output combinational paths.
- States: IDLE, SCAN, ADDR_PH, ADDR_WAIT, DATA_PH, DATA_WAIT, NEXT, DONE.
- IDLE: when start=1, capture reg_mask, set idx=0, clear err, go to SCAN. start in any other state is ignored.
- SCAN: if mask[idx]=1, go to ADDR_PH. If mask[idx]=0 and idx=N_REGS-1, go to DONE. Otherwise idx++ and stay in SCAN. Each skipped register costs one cycle.
- ADDR_PH: bus_start=1, ad_w=0, data_sel=00, clear timeout counter; go to ADDR_WAIT.
- ADDR_WAIT: on bus_done go to DATA_PH. Otherwise increment the counter; when counter=TIMEOUT, set err=1 and go to DONE.
- DATA_PH: bus_start=1, ad_w=1, data_sel=01, clear counter; go to DATA_WAIT.
- DATA_WAIT: bus_done and timeout handled as in ADDR_WAIT; on bus_done go to NEXT.
- NEXT: if idx=N_REGS-1 go to DONE, else idx++ and go to SCAN.
- DONE: done=1 for one cycle; return to IDLE.
- op_w=1 in every state except IDLE and DONE.
- Exactly one bus_start pulse per phase. bus_done seen in any state other than ADDR_WAIT or DATA_WAIT is ignored.
- bus_done arriving in the same cycle the counter reaches TIMEOUT: bus_done wins and there is no error.
- addr_w and sel_prog hold their values through both phases of a register. They change only in SCAN or NEXT.
- An all-zero mask produces no bus_start pulses; the sequence goes straight through SCAN to DONE with done=1.
- Changing reg_mask during operation has no effect, because the mask is captured on start.
- Reset asserted mid-transaction: next cycle is IDLE with all outputs at their reset values. No further bus_start is issued.
- err stays high after DONE until the next accepted start or a reset.

Test Plan:
- Mask 9'h1FF, bus_done 2 cycles after each bus_start -> 18 bus_start pulses. ad_w alternates 0,1. addr_w steps 0x21..0x29. One done pulse, err=0.
- Mask 9'b100000101 -> writes only indices 0, 2 and 8 (6 bus_start pulses). sel_prog = 0, 2, 8 during the phases. Skipped registers produce no bus_start.
- Mask 0 -> no bus_start. done pulses exactly once, N_REGS+1 cycles after start is sampled. busy falls with done.
- bus_done withheld in ADDR_WAIT of index 3 -> err=1 and done after TIMEOUT cycles, with no DATA_PH. Next start clears err.
- bus_done in the same cycle the counter equals TIMEOUT -> proceeds to DATA_PH, err=0. A spurious bus_done in IDLE or SCAN -> no state change.
- reset during DATA_WAIT of index 4 -> next cycle busy=0, op_w=0, idx=0. A subsequent start restarts the sequence from index 0.
